// File: rtl/async_fifo_pkg.sv
// Shared sizing defaults for the byte FIFO and its storage array.
package async_fifo_pkg;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 4;
    localparam int DEPTH          = 2 ** ADDR_WIDTH_DEF;
endpackage

// File: rtl/async_fifo_fifo_mem.sv
// Simple-dual-port register array: one write port, one registered read port.
module fifo_mem
    import async_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    // Storage is deliberately left unreset; only the output register clears.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = mem_q[raddr_i];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/async_fifo.sv
// Single-clock 16x8 FIFO: binary wrap pointers with an extra MSB, flags from registered pointers.
module async_fifo
    import async_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  winc,
    input  logic                  rinc,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  wenable,
    output logic                  renable
);
    logic [ADDR_WIDTH:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH:0] rptr_q, rptr_d;
    logic                full;
    logic                empty;
    logic                wr_acc;
    logic                rd_acc;

    // Same low bits with differing wrap bit means the writer is a full lap ahead.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]) &&
                   (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);

    assign wenable = !full;
    assign renable = !empty;
    assign wr_acc  = winc && wenable;
    assign rd_acc  = rinc && renable;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_acc) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (rd_acc) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk_i   (wclk),
        .rst_i   (wrst),
        .we_i    (wr_acc),
        .waddr_i (wptr_q[ADDR_WIDTH-1:0]),
        .wdata_i (wdata),
        .re_i    (rd_acc),
        .raddr_i (rptr_q[ADDR_WIDTH-1:0]),
        .rdata_o (rdata)
    );
endmodule

// File: tb/tb_async_fifo.sv
// Directed self-checking bench for the 16x8 single-clock FIFO.
module tb_async_fifo;
    logic       wclk = 1'b0;
    logic       wrst = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       winc = 1'b0;
    logic       rinc = 1'b0;
    logic [7:0] rdata;
    logic       wenable;
    logic       renable;

    int total = 0;
    int bad   = 0;

    async_fifo dut (
        .wclk    (wclk),
        .wrst    (wrst),
        .wdata   (wdata),
        .winc    (winc),
        .rinc    (rinc),
        .rdata   (rdata),
        .wenable (wenable),
        .renable (renable)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    initial begin
        // Reset
        wrst = 1'b1;
        tick();
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_wen", {7'b0, wenable}, 8'h01);
        chk("rst_ren", {7'b0, renable}, 8'h00);
        wrst = 1'b0;
        tick();

        // Streaming: write and read every edge
        winc = 1'b1; rinc = 1'b1; wdata = 8'h00;
        tick();
        chk("stream_e1_rdata", rdata, 8'h00);
        chk("stream_e1_ren", {7'b0, renable}, 8'h01);
        for (int k = 2; k <= 12; k++) begin
            wdata = 8'(k - 1);
            tick();
            chk("stream_rdata", rdata, 8'(k - 2));
            chk("stream_wen", {7'b0, wenable}, 8'h01);
            chk("stream_ren", {7'b0, renable}, 8'h01);
        end
        winc = 1'b0;
        tick();
        chk("stream_tail_rdata", rdata, 8'h0B);
        chk("stream_tail_ren", {7'b0, renable}, 8'h00);
        rinc = 1'b0;

        // Fill 16 entries
        winc = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wdata = 8'h10 + 8'(i);
            tick();
            chk("fill_wen", {7'b0, wenable}, (i == 15) ? 8'h00 : 8'h01);
        end
        wdata = 8'hAA;
        tick();
        chk("fill17_wen", {7'b0, wenable}, 8'h00);
        chk("fill17_ren", {7'b0, renable}, 8'h01);
        winc = 1'b0;

        // Drain 16 entries, then one read on empty
        rinc = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("drain_rdata", rdata, 8'h10 + 8'(i));
            chk("drain_ren", {7'b0, renable}, (i == 15) ? 8'h00 : 8'h01);
        end
        tick();
        chk("drain17_rdata", rdata, 8'h1F);
        chk("drain17_wen", {7'b0, wenable}, 8'h01);
        rinc = 1'b0;

        // Refill, then write+read while full
        winc = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wdata = 8'h10 + 8'(i);
            tick();
        end
        chk("refill_wen", {7'b0, wenable}, 8'h00);
        wdata = 8'h55; rinc = 1'b1;
        tick();
        chk("fullboth_rdata", rdata, 8'h10);
        chk("fullboth_wen", {7'b0, wenable}, 8'h01);
        winc = 1'b0;
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("fullboth_drain", rdata, 8'h10 + 8'(i));
        end
        chk("fullboth_empty", {7'b0, renable}, 8'h00);
        rinc = 1'b0;

        // Wrap: 40 words in blocks of 10
        for (int b = 0; b < 4; b++) begin
            winc = 1'b1;
            for (int i = 0; i < 10; i++) begin
                wdata = 8'h80 + 8'(b * 10 + i);
                tick();
            end
            winc = 1'b0; rinc = 1'b1;
            for (int i = 0; i < 10; i++) begin
                tick();
                chk("wrap_rdata", rdata, 8'h80 + 8'(b * 10 + i));
            end
            rinc = 1'b0;
        end
        chk("wrap_ren", {7'b0, renable}, 8'h00);

        // Mid-operation reset with 5 entries queued
        winc = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wdata = 8'hA0 + 8'(i);
            tick();
        end
        winc = 1'b0;
        chk("pre_rst_ren", {7'b0, renable}, 8'h01);
        #2;
        wrst = 1'b1;
        #1;
        chk("midrst_rdata", rdata, 8'h00);
        chk("midrst_wen", {7'b0, wenable}, 8'h01);
        chk("midrst_ren", {7'b0, renable}, 8'h00);
        tick();
        wrst = 1'b0;
        tick();
        chk("post_rst_ren", {7'b0, renable}, 8'h00);

        winc = 1'b1; wdata = 8'h77;
        tick();
        winc = 1'b0;
        chk("post_wr_ren", {7'b0, renable}, 8'h01);
        chk("post_wr_rdata", rdata, 8'h00);
        rinc = 1'b1;
        tick();
        rinc = 1'b0;
        chk("post_rd_rdata", rdata, 8'h77);
        chk("post_rd_ren", {7'b0, renable}, 8'h00);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/async_fifo.md
Name: async_fifo

Overview:
- Single-clock, 16-entry by 8-bit first-in-first-out buffer with registered read data and occupancy-derived status flags.
- Decouples a byte-stream producer from a consumer inside one clock domain.
- Write side pushes on winc.
- Read side pops on rinc.
- wenable and renable tell each side whether its request will be accepted.

Parameters:
- DATA_WIDTH, 8, width of wdata, rdata and each storage word.
- ADDR_WIDTH, 4, address bits; depth = 2**ADDR_WIDTH = 16 entries.

Ports:
- wclk  input  1  sole clock; all state updates on rising edge.
- wrst  input  1  asynchronous, active-high reset; clears pointers, flags, rdata.
- wdata  input  DATA_WIDTH  write data, sampled on a rising wclk edge when a write is accepted.
- winc  input  1  write request.
- rinc  input  1  read request.
- rdata  output  DATA_WIDTH  registered read data.
- wenable  output  1  high when FIFO is not full (a write would be accepted).
- renable  output  1  high when FIFO is not empty (a read would be accepted).

Behaviour:
- Interface: one clock (wclk); reset (wrst) is asynchronous and active-high.
- Storage: 2**ADDR_WIDTH words of DATA_WIDTH. Memory contents are not reset.
- Pointers: wptr and rptr are ADDR_WIDTH+1 bits binary and wrap naturally modulo 2**(ADDR_WIDTH+1). The low ADDR_WIDTH bits address memory.
- Empty: wptr == rptr.
- Full: MSBs differ and the low ADDR_WIDTH bits are equal.
- Flags are combinational from the registered pointers: wenable = !full, renable = !empty.
- Write accepted = winc && wenable. On that edge: mem[wptr] <= wdata, wptr <= wptr+1.
- Read accepted = rinc && renable. On that edge: rdata <= mem[rptr], rptr <= rptr+1. Latency: data appears on rdata immediately after the accepting edge.
- rdata holds its last value when no read is accepted.
- Write when full: ignored. No pointer or memory change, no error flag.
- Read when empty: ignored. rptr and rdata unchanged.
- Simultaneous write and read:
  - Both acceptance decisions use the flags at the start of the cycle.
  - When full, only the read occurs; occupancy becomes 15.
  - When empty, only the write occurs; occupancy becomes 1 and rdata is unchanged.
  - Otherwise both occur and occupancy is unchanged.
- There is no bypass: a word written on an edge is readable at the earliest on the following edge.
- Reset state (asserted at any time, including mid-stream): wptr=0, rptr=0, rdata=0, wenable=1, renable=0. All in-flight data is discarded.
- After deassertion, operation resumes on the next rising wclk.

Decomposition:
- Shared package holds DATA_WIDTH/ADDR_WIDTH defaults and a DEPTH localparam.
- One sub-module is natural: fifo_mem, a simple-dual-port register array with a write port and a registered read port.
- Pointer and flag logic stays in async_fifo.

Test Plan:
- Reset: assert wrst for 1 cycle with winc=rinc=0 -> rdata=0x00, wenable=1, renable=0.
- Streaming: after reset, hold winc=rinc=1 with wdata counting 0,1,2,... (incrementing every edge).
  - Edge 1: write 0x00, read ignored (empty); renable rises.
  - Edge 2 onward: rdata = 0x00, 0x01, 0x02, ..., trailing each written value by one edge.
  - Occupancy stays 1; wenable stays 1.
- Fill: winc=1, rinc=0 for 16 edges with wdata 0x10..0x1F -> wenable falls after the 16th edge.
  - A 17th write of 0xAA is ignored and wptr is unchanged.
- Drain: rinc=1, winc=0 for 16 edges -> rdata = 0x10..0x1F in order; renable falls after the last.
  - A 17th read leaves rdata=0x1F.
- Full plus both requests: with 16 entries, winc=rinc=1 with wdata=0x55 -> rdata=0x10, wenable rises, 0x55 is not stored.
- Wrap and mid-operation reset:
  - Write/read 40 words (pointers wrap) -> data order preserved.
  - Assert wrst with 5 entries queued -> wenable=1, renable=0, rdata=0x00 immediately.
  - A following write of 0x77 then a read -> rdata=0x77.
